ip_counting_burst_mem: RTL
==========================

Name: ip_counting_burst_mem

Overview:
AXI4 (full) slave burst memory: the parametrised successor of the fixed 32-bit, 8-beat counting IP. It supports configurable data width, memory depth and ID width, plus FIXED, INCR and WRAP bursts, byte strobes and arbitrated read/write. It sits behind the block-design interconnect as the S00_AXI endpoint that the VIP master exercises.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, data bus width in bits; legal values 32, 64, 128.
C_S00_AXI_ADDR_WIDTH, 12, byte address width.
C_S00_AXI_ID_WIDTH, 1, AWID/ARID width; IDs are echoed on BID/RID.
C_MEM_DEPTH, 256, number of data-width words; power of two.

Ports:
s00_axi_aclk  in  1  clock; all logic is on the rising edge
s00_axi_aresetn  in  1  synchronous, active-low reset
s00_axi_awid/awaddr/awlen[8]/awsize[3]/awburst[2]/awvalid  in  ID/ADDR/8/3/2/1  write address
s00_axi_awready  out  1
s00_axi_wdata/wstrb/wlast/wvalid  in  DATA/DATA/8/1/1  write data
s00_axi_wready  out  1
s00_axi_bid/bresp[2]/bvalid  out  ID/2/1;  s00_axi_bready in 1
s00_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  as AW;  s00_axi_arready out 1
s00_axi_rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1;  s00_axi_rready in 1
wr_beat_cnt, rd_beat_cnt  out  32  (present only with IP_COUNTING_STATS_EN)

Behaviour:
- Reset (sampled with aresetn=0 at a clock edge): every ready/valid output is 0; bresp, rresp, bid, rid, rdata and rlast are 0; the FSM goes to IDLE; stats counters are 0. Memory contents are not cleared.
- Reset mid-burst: the transaction is abandoned and no B or R response is issued. Words already written stay written.
- FSM states: IDLE, WDATA, WRESP, RDATA. Only one transaction is in flight at a time.
- IDLE: awready and arready are registered high. If awvalid and arvalid are both high in the same cycle, the write wins and arready drops for that cycle. On the AW handshake the block latches id, address, len, burst and size, then moves to WDATA. On the AR handshake it latches the same fields and moves to RDATA.
- WDATA: wready=1. Each W handshake writes the bytes enabled by wstrb to mem[addr_idx], then advances the address.
  - The beat counter reaching awlen ends the burst and the FSM moves to WRESP.
  - wlast is checked against the beat count. A mismatch sets bresp=SLVERR (2'b10). The burst still ends after awlen+1 beats; the FSM does not wait on wlast.
- WRESP: bvalid=1 with bid=latched id. bresp is OKAY unless flagged. After the B handshake the FSM returns to IDLE; awready is high again on the next cycle.
- RDATA: rvalid asserts one cycle after the AR handshake. rdata is held stable while rvalid=1 and rready=0. Each R handshake advances to the next beat with no bubble. rlast=1 on beat arlen. After the last handshake the FSM returns to IDLE. rresp is always OKAY.
- Address generation (word index = addr >> log2(DATA_WIDTH/8), modulo C_MEM_DEPTH):
  - FIXED: the address is constant.
  - INCR: the address adds 2^size per beat. Crossing C_MEM_DEPTH wraps silently to word 0.
  - WRAP: the boundary is (len+1)*2^size and the address wraps within the aligned window. len must be 1, 3, 7 or 15; any other len is treated as INCR.
  - Reserved burst 2'b11 is treated as INCR; write bursts of this type get bresp=SLVERR.
- Narrow transfers (size < bus width): the address steps by 2^size. Data lanes are not realigned; the master supplies wstrb.
- Unaligned INCR start: the first beat uses the given address and later beats are aligned.

Optional Feature:
Macro IP_COUNTING_STATS_EN.
- Defined: the wr_beat_cnt and rd_beat_cnt ports exist. Each increments by 1 per W or R handshake, saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: the ports and counters are absent and the core behaviour is unchanged.

Test Plan:
1. 32-bit bus, INCR len=7 write of 1..8 at 0x0, then INCR len=7 read at 0x0 -> rdata is 1..8, rlast only on beat 8, bresp=OKAY, rresp=OKAY.
2. WRAP len=3 read at 0x8 after memory is preloaded with word i = i+1 -> rdata order 3,4,1,2 (addresses 0x8, 0xC, 0x0, 0x4).
3. FIXED len=3 write to 0x10 with data A,B,C,D and wstrb 1111,0001,1111,0010 -> reading 0x10 returns D's byte1 merged over C.
4. awvalid and arvalid asserted in the same cycle -> the AW handshake happens first, the B response completes, and arready rises only after return to IDLE. The read returns the newly written data.
5. aresetn pulled low after write beat 3 of 8 -> all valids are 0 the next cycle and no bvalid appears. A subsequent read shows words 0-2 updated and words 3-7 old.
6. With IP_COUNTING_STATS_EN: test 1 followed by rready throttled 50% -> wr_beat_cnt=8 and rd_beat_cnt=8, with rdata stable during stalls.

Source files
------------

// File: rtl/ip_counting_burst_mem_if.sv
// AXI4 (full) bundle for ip_counting_burst_mem: the master modport issues bursts
// and the slave modport answers them.
interface ip_counting_burst_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int ID_WIDTH   = 1
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      output rready,
      input  awready, wready, bid, bresp, bvalid, arready,
      input  rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      input  rready,
      output awready, wready, bid, bresp, bvalid, arready,
      output rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/ip_counting_burst_mem.sv
// AXI4 slave burst memory (FIXED/INCR/WRAP, byte strobes, one transaction in flight).
// Define IP_COUNTING_STATS_EN to add saturating wr_beat_cnt / rd_beat_cnt ports.
module ip_counting_burst_mem #(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 12,
   parameter int C_S00_AXI_ID_WIDTH   = 1,
   parameter int C_MEM_DEPTH          = 256
) (
   input  logic                   s00_axi_aclk,
   input  logic                   s00_axi_aresetn,
   ip_counting_burst_mem_if.slave s00_axi
`ifdef IP_COUNTING_STATS_EN
   ,
   output logic [31:0]            wr_beat_cnt,
   output logic [31:0]            rd_beat_cnt
`endif
);

   localparam int DW       = C_S00_AXI_DATA_WIDTH;
   localparam int AW       = C_S00_AXI_ADDR_WIDTH;
   localparam int IW       = C_S00_AXI_ID_WIDTH;
   localparam int STRB_W   = DW / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(C_MEM_DEPTH);

   localparam logic [AW-1:0] ONE = AW'(1);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   state_t          state;
   logic [IW-1:0]   id_q;
   logic [AW-1:0]   addr_q;
   logic [7:0]      len_q;
   logic [2:0]      size_q;
   logic [1:0]      burst_q;
   logic [7:0]      beat_q;
   logic            wr_err_q;

   logic            awready_q, arready_q, wready_q;
   logic            bvalid_q, rvalid_q, rlast_q;
   logic [IW-1:0]   bid_q, rid_q;
   logic [1:0]      bresp_q;
   logic [DW-1:0]   rdata_q;

   logic [DW-1:0]   mem [C_MEM_DEPTH];

   logic [AW-1:0]   step, aligned, incr_addr, wrap_len, wrap_base, next_addr;
   logic            wrap_ok;
   logic [IDX_W-1:0] word_idx;
   logic            aw_hs, ar_hs, w_hs, r_hs, b_hs, wlast_bad, mem_we;

   assign word_idx  = addr_q[ADDR_LSB +: IDX_W];
   assign aw_hs     = awready_q && s00_axi.awvalid;
   assign ar_hs     = arready_q && s00_axi.arvalid && !s00_axi.awvalid;
   assign w_hs      = wready_q && s00_axi.wvalid;
   assign r_hs      = rvalid_q && s00_axi.rready;
   assign b_hs      = bvalid_q && s00_axi.bready;
   assign wlast_bad = s00_axi.wlast != (beat_q == len_q);
   assign mem_we    = s00_axi_aresetn && (state == WDATA) && w_hs;

   // Writes win a same-cycle tie, so arready is masked while awvalid is up.
   assign s00_axi.awready = awready_q;
   assign s00_axi.arready = arready_q && !s00_axi.awvalid;
   assign s00_axi.wready  = wready_q;
   assign s00_axi.bvalid  = bvalid_q;
   assign s00_axi.bid     = bid_q;
   assign s00_axi.bresp   = bresp_q;
   assign s00_axi.rvalid  = rvalid_q;
   assign s00_axi.rid     = rid_q;
   assign s00_axi.rdata   = rdata_q;
   assign s00_axi.rlast   = rlast_q;
   assign s00_axi.rresp   = RESP_OKAY;

   // Next byte address of the beat after addr_q; later INCR beats are size-aligned.
   always_comb begin
      // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
      step      = ONE << size_q;
      aligned   = addr_q & ~(step - ONE);
      incr_addr = aligned + step;
      wrap_len  = (AW'(len_q) + ONE) << size_q;
      wrap_base = addr_q & ~(wrap_len - ONE);
      wrap_ok   = len_q inside {8'd1, 8'd3, 8'd7, 8'd15};
      next_addr = incr_addr;
      case (burst_q)
         BURST_FIXED: next_addr = addr_q;
         BURST_WRAP:  if (wrap_ok) next_addr = wrap_base | (incr_addr & (wrap_len - ONE));
         default:     next_addr = incr_addr;
      endcase
   end

   // NOTE: the array has no reset; contents deliberately survive aresetn and it stays RAM-mappable.
   always_ff @(posedge s00_axi_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s00_axi.wstrb[b]) mem[word_idx][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
      if (!s00_axi_aresetn) begin
         state     <= IDLE;
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         beat_q    <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               awready_q <= 1'b1;
               arready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q <= 1'b0;
                  arready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  id_q      <= s00_axi.awid;
                  addr_q    <= s00_axi.awaddr;
                  len_q     <= s00_axi.awlen;
                  size_q    <= s00_axi.awsize;
                  burst_q   <= s00_axi.awburst;
                  beat_q    <= '0;
                  wr_err_q  <= (s00_axi.awburst == BURST_RSVD);
                  state     <= WDATA;
               end else if (ar_hs) begin
                  awready_q <= 1'b0;
                  arready_q <= 1'b0;
                  id_q      <= s00_axi.arid;
                  addr_q    <= s00_axi.araddr;
                  len_q     <= s00_axi.arlen;
                  size_q    <= s00_axi.arsize;
                  burst_q   <= s00_axi.arburst;
                  beat_q    <= '0;
                  state     <= RDATA;
               end
            end

            // The burst length alone ends a write; wlast only feeds the error flag.
            WDATA: begin
               if (w_hs) begin
                  addr_q   <= next_addr;
                  beat_q   <= beat_q + 8'd1;
                  wr_err_q <= wr_err_q || wlast_bad;
                  if (beat_q == len_q) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= (wr_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                     state    <= WRESP;
                  end
               end
            end

            WRESP: begin
               if (b_hs) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  arready_q <= 1'b1;
                  state     <= IDLE;
               end
            end

            // addr_q always points at the beat to fetch next, so back-to-back beats need no bubble.
            RDATA: begin
               if (!rvalid_q) begin
                  rvalid_q <= 1'b1;
                  rid_q    <= id_q;
                  rdata_q  <= mem[word_idx];
                  rlast_q  <= (len_q == 8'd0);
                  addr_q   <= next_addr;
               end else if (r_hs) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     awready_q <= 1'b1;
                     arready_q <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     rdata_q <= mem[word_idx];
                     rlast_q <= ((beat_q + 8'd1) == len_q);
                     beat_q  <= beat_q + 8'd1;
                     addr_q  <= next_addr;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef IP_COUNTING_STATS_EN
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         wr_beat_cnt <= '0;
         rd_beat_cnt <= '0;
      end else begin
         if (w_hs && wr_beat_cnt != 32'hFFFF_FFFF) wr_beat_cnt <= wr_beat_cnt + 32'd1;
         if (r_hs && rd_beat_cnt != 32'hFFFF_FFFF) rd_beat_cnt <= rd_beat_cnt + 32'd1;
      end
   end
`endif

endmodule
